// File: rtl/product_sign_restore.sv
// Sign restoration and output buffering for the unsigned multiplier core: S1 registers the sign and
// magnitude, S2 forms the two's-complement product, and a FIFO with reserved slots buffers results.
// Define SIGN_RESTORE_ROUND_EN to round the magnitude half-up to its upper half (OW = WIDTH+2).
module product_sign_restore #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
`ifdef SIGN_RESTORE_ROUND_EN
    localparam int OW = WIDTH + 2,
`else
    localparam int OW = 2 * WIDTH + 1,
`endif
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [2*WIDTH-1:0]   in_mag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_p,
    output logic [CW-1:0]        count
);

    localparam int MW  = 2 * WIDTH;
    localparam int PW  = $clog2(DEPTH);
    localparam int OCW = CW + 1;

    logic                 v1_q, v1_d;
    logic                 s1_sign_q, s1_sign_d;
    logic [MW-1:0]        s1_mag_q, s1_mag_d;
    logic                 v2_q, v2_d;
    logic signed [OW-1:0] s2_p_q, s2_p_d;
    logic [PW-1:0]        wp_q, wp_d;
    logic [PW-1:0]        rp_q, rp_d;
    logic [CW-1:0]        count_q, count_d;
    logic signed [OW-1:0] mem_q [DEPTH];
    logic signed [OW-1:0] mem_d [DEPTH];

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [OCW-1:0]       occupancy;

`ifdef SIGN_RESTORE_ROUND_EN
    localparam int RW = WIDTH + 1;

    function automatic logic [RW-1:0] round_half_up(input logic [MW-1:0] mag);
        round_half_up = {1'b0, mag[MW-1:WIDTH]} + RW'(mag[WIDTH-1]);
    endfunction
`endif

    // A zero magnitude never becomes negative, so -0 always leaves as +0.
    function automatic logic signed [OW-1:0] restore_sign(input logic neg, input logic [MW-1:0] mag);
        logic [OW-1:0] ext;
`ifdef SIGN_RESTORE_ROUND_EN
        ext = {1'b0, round_half_up(mag)};
`else
        ext = {1'b0, mag};
`endif
        if (neg && (ext != '0)) begin
            restore_sign = ~ext + OW'(1);
        end else begin
            restore_sign = ext;
        end
    endfunction

    // Every product in S1/S2 already owns a FIFO slot; this keeps in_ready off in_valid/out_ready.
    always_comb begin
        occupancy = {1'b0, count_q} + OCW'(v1_q) + OCW'(v2_q);
        in_ready  = (occupancy < OCW'(DEPTH));
    end

    assign accept    = in_valid & in_ready;
    assign push      = v2_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_p     = mem_q[rp_q];
    assign count     = count_q;

    always_comb begin
        // S1: capture the accepted product
        v1_d      = accept;
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        if (accept) begin
            s1_sign_d = in_sign;
            s1_mag_d  = in_mag;
        end

        // S2: signed conversion
        v2_d   = v1_q;
        s2_p_d = s2_p_q;
        if (v1_q) begin
            s2_p_d = restore_sign(s1_sign_q, s1_mag_q);
        end

        // FIFO: write behind S2, read at the head
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            mem_d[wp_q] = s2_p_q;
            wp_d        = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            v2_q      <= 1'b0;
            s2_p_q    <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            v1_q      <= v1_d;
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            v2_q      <= v2_d;
            s2_p_q    <= s2_p_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_product_sign_restore.sv
// Directed bench for product_sign_restore at WIDTH=8, DEPTH=4 (both build variants of the rounding option).
module tb_product_sign_restore;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef SIGN_RESTORE_ROUND_EN
    localparam int OW = WIDTH + 2;
`else
    localparam int OW = 2 * WIDTH + 1;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [15:0]   in_mag;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_p;
    logic [2:0]    count;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic          s;
        logic [15:0]   m;
        logic [OW-1:0] p;
    } vec_t;
    vec_t vecs [4];

    product_sign_restore #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .count     (count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] gen_mag(input int i);
        gen_mag = 16'(i * 16'h1357 + 16'h0081);
    endfunction

    // Reference: negative result is 2^OW minus the (optionally rounded) magnitude.
    function automatic logic [OW-1:0] model(input logic s, input logic [15:0] m);
        int unsigned mg;
`ifdef SIGN_RESTORE_ROUND_EN
        mg = (int'(m) + 128) >> 8;
`else
        mg = int'(m);
`endif
        if (s && mg != 0) model = OW'((32'd1 << OW) - mg);
        else              model = OW'(mg);
    endfunction

    initial begin
        int acc;
        int sent;
        int popped;
        int maxc;
        logic r;
        logic stale;

`ifdef SIGN_RESTORE_ROUND_EN
        vecs[0] = '{1'b1, 16'h1280, 10'h3ED};
        vecs[1] = '{1'b0, 16'h127F, 10'h012};
        vecs[2] = '{1'b1, 16'h0000, 10'h000};
        vecs[3] = '{1'b1, 16'hFFFF, 10'h300};
`else
        vecs[0] = '{1'b1, 16'h0006, 17'h1FFFA};
        vecs[1] = '{1'b1, 16'h0000, 17'h00000};
        vecs[2] = '{1'b0, 16'hFFFF, 17'h0FFFF};
        vecs[3] = '{1'b1, 16'hFFFF, 17'h10001};
`endif

        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mag    = '0;
        out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_p",     32'(out_p),     32'd0);
        tick();
        Rst = 1'b1;
        tick();

        // Latency of a single product
        in_sign  = vecs[0].s;
        in_mag   = vecs[0].m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        check("lat_n0_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge Clk);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge Clk);
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_p",     32'(out_p),     32'(vecs[0].p));
        tick();
        @(negedge Clk);
        check("lat_n3_popped", 32'(out_valid), 32'd0);

        // Remaining directed vectors back to back
        tick();
        for (int k = 1; k < 4; k++) begin
            in_sign  = vecs[k].s;
            in_mag   = vecs[k].m;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge Clk);
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_p", k),     32'(out_p),     32'(vecs[k].p));
            tick();
        end
        @(negedge Clk);
        check("vec_drained", 32'(out_valid), 32'd0);
        tick();

        // Backpressure: six offered, four accepted
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (acc < 6);
            in_sign  = acc[0];
            in_mag   = gen_mag(acc);
            @(negedge Clk);
            r = in_ready;
            tick();
            if (r && in_valid) acc++;
        end
        in_valid = 1'b0;
        @(negedge Clk);
        check("bp_accepted", 32'(acc),      32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count",    32'(count),    32'd4);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check($sformatf("bp_pop%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_pop%0d_p", k),     32'(out_p),     32'(model(k[0], gen_mag(k))));
            tick();
        end
        @(negedge Clk);
        check("bp_recover_ready", 32'(in_ready),  32'd1);
        check("bp_empty",         32'(out_valid), 32'd0);
        tick();

        // Streaming 16 products with out_ready toggling
        sent   = 0;
        popped = 0;
        maxc   = 0;
        for (int c = 0; c < 200 && popped < 16; c++) begin
            in_valid  = (sent < 16);
            in_sign   = sent[1];
            in_mag    = gen_mag(sent + 7);
            out_ready = (c % 2 == 0);
            @(negedge Clk);
            r = in_ready;
            if (int'(count) > maxc) maxc = int'(count);
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d_p", popped), 32'(out_p),
                      32'(model(popped[1], gen_mag(popped + 7))));
                popped++;
            end
            tick();
            if (r && in_valid) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent",   32'(sent),   32'd16);
        check("stream_popped", 32'(popped), 32'd16);
        check("stream_max_count_le_depth", 32'(maxc <= DEPTH), 32'd1);
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (out_valid) stale = 1'b1;
            tick();
        end
        check("stream_no_extra", 32'(stale), 32'd0);

        // Reset with two products in the FIFO and two in S1/S2
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_mag   = gen_mag(20 + k);
            tick();
        end
        in_valid = 1'b0;
        @(negedge Clk);
        check("pre_rst_count", 32'(count), 32'd2);
        #1;
        Rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count",     32'(count),     32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        tick();
        Rst       = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (out_valid) stale = 1'b1;
            tick();
        end
        check("postrst_no_stale", 32'(stale), 32'd0);

        // Block still works after the reset
        in_sign  = vecs[3].s;
        in_mag   = vecs[3].m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge Clk);
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_p",     32'(out_p),     32'(vecs[3].p));
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/product_sign_restore.md
# product_sign_restore

Downstream stage of the approximate unsigned multiplier core. It consumes the unsigned magnitude product and the combined operand sign (x_sign XOR y_sign) and converts the pair to a two's-complement signed product. The result is held in a small first-word-fall-through output FIFO behind a valid/ready handshake. The block completes the signed datapath: sign-magnitude operands go in, the unsigned core multiplies, and this block restores the sign and buffers results for the consumer.

## Interface
Parameters:
- WIDTH, 128, operand width of the multiplier core; the magnitude input is 2*WIDTH bits.
- DEPTH, 4, output FIFO entries; a power of two, at least 2.
- OW (derived, not overridable): 2*WIDTH+1, or WIDTH+2 when rounding is compiled in.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  the upstream product is valid.
- in_ready  out  1  the block accepts a product this cycle.
- in_sign  in  1  result sign: 1 means negative.
- in_mag  in  2*WIDTH  unsigned product magnitude.
- out_valid  out  1  the FIFO head is valid.
- out_ready  in  1  the consumer takes the head this cycle.
- out_p  out  OW  signed product at the FIFO head.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- A transfer occurs when in_valid and in_ready are both high at a rising edge. in_sign and in_mag are sampled at that edge.
- Pipeline stage S1 registers the sign, magnitude and valid bit.
- Pipeline stage S2 performs the conversion and registers it with its valid bit:
  - If sign=1 and magnitude≠0, the result is the two's complement of the zero-extended magnitude (~{1'b0,mag}+1) at OW bits.
  - Otherwise the result is the zero-extended magnitude.
  - Negative zero maps to +0.
- A valid S2 entry is written to the FIFO at the next edge, unconditionally.
- The FIFO is a circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - out_p always shows mem[rp].
  - out_valid = (count≠0).
- Pop: out_valid and out_ready at an edge advances rp.
- Flow control: in_ready = (count + v1 + v2) < DEPTH, where v1 and v2 are the S1 and S2 valid bits.
  - Every in-flight entry therefore has a reserved slot, so S2 never stalls and the FIFO never overflows.
  - A write into a full FIFO is impossible by construction. The bench asserts that it never happens.
- Simultaneous push and pop in the same cycle leaves count unchanged; both pointers advance.
- The pipeline does not stall. S1 and S2 advance every cycle, and bubbles propagate as valid=0.

## Timing
- Reset (Rst=0, asynchronous) clears S1, S2, wp, rp and count:
  - out_valid=0, count=0, in_ready=1 immediately.
  - out_p is X-free 0, because memory entry 0 is reset.
- Reset asserted mid-operation discards all in-flight and buffered products; no partial output follows.
- Latency: a product accepted at edge N sits in S1 after N, in S2 after N+1, and in the FIFO after N+2. out_valid rises after edge N+2, so the earliest pop is at edge N+3.
- Throughput is one product per cycle while out_ready=1 is held.
- in_ready is combinational from registered state only. It has no path from in_valid, and no path from out_ready.
- With out_ready=0 held, exactly DEPTH products are accepted. in_ready then stays low until a pop.

## Configuration
- SIGN_RESTORE_ROUND_EN undefined: the full-precision path is used and OW=2*WIDTH+1.
- SIGN_RESTORE_ROUND_EN defined: S2 rounds the magnitude half-up to its upper half, then applies the sign rule, and OW=WIDTH+2.
  - The rounded magnitude is {1'b0,mag[2W-1:W]} + mag[W-1], at WIDTH+1 bits.
  - The FIFO width follows OW.
  - Latency and handshake are unchanged.

## Test plan
Bench parameters: WIDTH=8, DEPTH=4, out_ready=1 unless stated.
- Sign 1, mag 16'h0006 → out_p=17'h1FFFA, with out_valid rising after edge N+2.
- Sign 1, mag 16'h0000 → out_p=17'h00000. Sign 0, mag 16'hFFFF → out_p=17'h0FFFF. Sign 1, mag 16'hFFFF → out_p=17'h10001.
- Hold out_ready=0 and offer 6 back-to-back products → exactly 4 accepted, in_ready low after the 4th, count reaches 4. Then raise out_ready → all 4 emerge in order and in_ready recovers.
- Full-rate streaming of 16 products while out_ready toggles 1,0,1,0 → all 16 emerge in order with no loss or duplication, and count never exceeds 4.
- Assert Rst low for 1 cycle while 2 products are in S1/S2 and 2 are in the FIFO → out_valid=0, count=0, in_ready=1. No stale result appears afterwards.
- With SIGN_RESTORE_ROUND_EN defined: sign 1, mag 16'h1280 → out_p=10'h3ED (−0x13). Sign 0, mag 16'h127F → out_p=10'h012.
